// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared sizes, state type and line-address helper for the memory arbiter
package mem_arb_pkg;
  localparam int LINE_WORDS = 8;
  localparam int WORD_BYTES = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam int WORD_W = $clog2(LINE_WORDS);
  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_WORDS * WORD_BYTES - 1);
  endfunction
endpackage

// File: rtl/mem_arbiter_line_fill_seq.sv
// line_fill_seq: issues the reads of one line fill and counts returned words until the line is complete
module line_fill_seq
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              active,
  input  logic              rvalid,
  input  logic [ADDR_W-1:0] addr,
  output logic              issue,
  output logic              we,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] word
);
  logic [CNT_W-1:0] issue_cnt, recv_cnt;
  logic [ADDR_W-1:0] base;
  assign issue = active && issue_cnt < CNT_W'(LINE_WORDS);
  assign we = active && rvalid;
  // completion is taken on the last returned word, so done coincides with the final write strobe
  assign done = we && recv_cnt == CNT_W'(LINE_WORDS - 1);
  assign word = recv_cnt[WORD_W-1:0];
  assign rd_addr = base + ADDR_W'(issue_cnt) * ADDR_W'(WORD_BYTES);
  always_ff @(posedge clk) begin
    if (rst || done) begin
      issue_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      issue_cnt <= issue_cnt + CNT_W'(issue);
      recv_cnt <= recv_cnt + CNT_W'(we);
    end
    if (rst) base <= '0;
    else if (load) base <= line_base(addr);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates I/D line fills and D write-through stores onto the single memory port
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_en,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_busy,
  output logic              i_fill_we,
  output logic [WORD_W-1:0] i_fill_word,
  output logic              i_fill_done,
  output logic              d_busy,
  output logic              d_fill_we,
  output logic [WORD_W-1:0] d_fill_word,
  output logic              d_fill_done,
  output logic              d_wr_ack
);
  state_t state, state_n, cur;
  logic load, issue, we, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] word;
  // outputs decode as IDLE while rst is held, so an abandoned fill never strobes a cache
  assign cur = rst ? IDLE : state;
  assign load = cur == IDLE && (state_n == FILL_I || state_n == FILL_D);
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (d_wr ? WRITE : d_miss ? FILL_D : i_miss ? FILL_I : IDLE) :
              state == WRITE ? IDLE : done ? IDLE : state;
  end
  line_fill_seq u_seq (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .active  (cur == FILL_I || cur == FILL_D),
    .rvalid  (mem_rvalid),
    .addr    (state_n == FILL_D ? d_addr : i_addr),
    .issue   (issue),
    .we      (we),
    .done    (done),
    .rd_addr (rd_addr),
    .word    (word)
  );
  assign mem_wr = cur == WRITE;
  assign mem_en = mem_wr || issue;
  assign mem_addr = mem_wr ? d_wr_addr : issue ? rd_addr : '0;
  assign mem_wdata = mem_wr ? d_wr_data : '0;
  assign fill_data = we ? mem_rdata : '0;
  assign i_busy = cur == FILL_I;
  assign i_fill_we = we && i_busy;
  assign i_fill_word = i_fill_we ? word : '0;
  assign i_fill_done = done && i_busy;
  assign d_busy = cur == FILL_D || mem_wr;
  assign d_fill_we = we && cur == FILL_D;
  assign d_fill_word = d_fill_we ? word : '0;
  assign d_fill_done = done && cur == FILL_D;
  assign d_wr_ack = mem_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  logic clk, rst;
  logic i_miss, d_miss, d_wr, mem_rvalid;
  logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic mem_wr, mem_en, i_busy, i_fill_we, i_fill_done, d_busy, d_fill_we, d_fill_done, d_wr_ack;
  logic [2:0] i_fill_word, d_fill_word;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_en(mem_en), .fill_data(fill_data), .i_busy(i_busy), .i_fill_we(i_fill_we),
    .i_fill_word(i_fill_word), .i_fill_done(i_fill_done), .d_busy(d_busy), .d_fill_we(d_fill_we),
    .d_fill_word(d_fill_word), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {int due; logic [15:0] d;} rd_t;
  rd_t q[$];
  logic [15:0] mem [int];
  int checks = 0, errors = 0, cyc = 0, lat = 4;
  // model: current operation (0 idle, 1 store, 2 I fill, 3 D fill), line base, words issued/received
  int mk = 0, mis = 0, mrx = 0;
  logic [15:0] mb = 0;
  bit auto_rel = 1, rel_i, rel_d, rel_w, stray_arm, stray_now;
  int n_iss, n_we_i, n_we_d, n_done_i, n_done_d, n_ack, n_busy_i, n_wr_early;
  int t_first_iss, t_first_we, t_done_i, t_ack, gap;
  bit gap_arm;
  logic [15:0] first_addr, last_addr;
  logic [23:0] ord = 0;

  function automatic logic [15:0] rd(logic [15:0] a);
    return mem.exists(int'(a[15:1])) ? mem[int'(a[15:1])] : {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic logic [62:0] outs();
    return {mem_addr, mem_wdata, mem_wr, mem_en, fill_data, i_busy, i_fill_we, i_fill_word, i_fill_done,
            d_busy, d_fill_we, d_fill_word, d_fill_done, d_wr_ack};
  endfunction

  function automatic logic [15:0] rnd_addr();
    return $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 511));
  endfunction

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic clr();
    {n_iss, n_we_i, n_we_d, n_done_i, n_done_d, n_ack, n_busy_i, n_wr_early} = '0;
    t_first_iss = -1; t_first_we = -1; t_done_i = -1; t_ack = -1; gap = -1; gap_arm = 0;
  endtask

  task automatic tick();
    int k;
    logic rx, iss;
    logic [15:0] ea;
    logic [62:0] e;
    @(negedge clk);
    k = rst ? 0 : mk;
    rx = k >= 2 && mem_rvalid;
    iss = k >= 2 && mis < 8;
    ea = k == 1 ? d_wr_addr : iss ? mb + 16'(2 * mis) : 16'h0;
    e = {ea, k == 1 ? d_wr_data : 16'h0, k == 1, k == 1 || iss, rx ? rd(mb + 16'(2 * mrx)) : 16'h0,
         k == 2, rx && k == 2, (rx && k == 2) ? 3'(mrx) : 3'h0, rx && k == 2 && mrx == 7,
         k == 1 || k == 3, rx && k == 3, (rx && k == 3) ? 3'(mrx) : 3'h0, rx && k == 3 && mrx == 7, k == 1};
    chk($sformatf("cycle %0d outputs", cyc), 64'(outs()), 64'(e));
    if (mem_en && !mem_wr) begin
      if (t_first_iss < 0) begin t_first_iss = cyc; first_addr = mem_addr; end
      last_addr = mem_addr;
      n_iss++;
      if (gap_arm) begin gap = cyc - t_done_i; gap_arm = 0; end
      q.push_back(rd_t'{cyc + lat, rd(mem_addr)});
    end
    if (mem_en && mem_wr) begin
      mem[int'(mem_addr[15:1])] = mem_wdata;
      if (n_done_i == 0) n_wr_early++;
    end
    if ((i_fill_we || d_fill_we) && t_first_we < 0) t_first_we = cyc;
    if (i_fill_we) n_we_i++;
    if (d_fill_we) n_we_d++;
    if (i_busy) n_busy_i++;
    if (i_fill_done) begin n_done_i++; t_done_i = cyc; gap_arm = 1; ord = {ord[15:0], 8'h49}; end
    if (d_fill_done) begin n_done_d++; ord = {ord[15:0], 8'h44}; end
    if (d_wr_ack) begin n_ack++; t_ack = cyc; ord = {ord[15:0], 8'h57}; end
    rel_i = i_fill_done; rel_d = d_fill_done; rel_w = d_wr_ack;
    if (rst) begin mk = 0; mis = 0; mrx = 0; end
    else if (mk == 0) begin
      if (d_wr) mk = 1;
      else if (d_miss) begin mk = 3; mb = d_addr & 16'hFFF0; end
      else if (i_miss) begin mk = 2; mb = i_addr & 16'hFFF0; end
    end else if (mk == 1) mk = 0;
    else begin
      if (iss) mis++;
      if (rx) mrx++;
      if (mrx == 8) begin mk = 0; mis = 0; mrx = 0; end
    end
    if (stray_arm && mk == 0 && q.size() == 0) begin stray_now = 1; stray_arm = 0; end
    @(posedge clk);
    cyc++;
    #1;
    mem_rvalid = 0;
    mem_rdata = 16'($urandom);
    if (q.size() != 0 && q[0].due == cyc) begin
      mem_rvalid = 1;
      mem_rdata = q[0].d;
      void'(q.pop_front());
    end else if (stray_now) mem_rvalid = 1;
    stray_now = 0;
    if (auto_rel) begin
      if (rel_i) i_miss = 0;
      if (rel_d) d_miss = 0;
      if (rel_w) d_wr = 0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (q.size() != 0 || mk != 0); n++) tick();
  endtask

  initial begin
    {i_miss, d_miss, d_wr, mem_rvalid, stray_arm, stray_now} = '0;
    {i_addr, d_addr, d_wr_addr, d_wr_data, mem_rdata} = '0;
    rst = 1;
    clr();
    tick(); tick();
    rst = 0;
    #2 chk("reset outputs", 64'(outs()), 64'h0);
    // single I fill, latency 4
    clr(); i_addr = 16'h1236; i_miss = 1;
    for (int n = 0; n < 60 && n_done_i == 0; n++) tick();
    repeat (3) tick();
    chk("ifill first addr", 64'(first_addr), 64'h1230);
    chk("ifill last addr", 64'(last_addr), 64'h123E);
    chk("ifill reads", 64'(n_iss), 64'd8);
    chk("ifill writes", 64'(n_we_i), 64'd8);
    chk("ifill busy cycles", 64'(n_busy_i), 64'd12);
    chk("ifill done pulses", 64'(n_done_i), 64'd1);
    chk("ifill latency", 64'(t_first_we - t_first_iss), 64'd4);
    // all three requests together
    drain(); clr();
    d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; d_wr = 1;
    d_addr = 16'h2000; d_miss = 1; i_addr = 16'h0100; i_miss = 1;
    for (int n = 0; n < 100 && n_done_i == 0; n++) tick();
    repeat (2) tick();
    chk("grant order", 64'(ord), 64'h574449);
    chk("store ack pulses", 64'(n_ack), 64'd1);
    chk("stored word", 64'(rd(16'h0040)), 64'hBEEF);
    chk("two fills reads", 64'(n_iss), 64'd16);
    // store arriving during an I fill
    drain(); clr(); i_addr = 16'h0300; i_miss = 1;
    for (int n = 0; n < 20 && n_busy_i < 2; n++) tick();
    d_wr_addr = 16'h0310; d_wr_data = 16'h1234; d_wr = 1;
    for (int n = 0; n < 60 && n_ack == 0; n++) tick();
    tick();
    chk("writes before done", 64'(n_wr_early), 64'd0);
    chk("store after done", 64'(t_ack - t_done_i), 64'd2);
    chk("store data", 64'(rd(16'h0310)), 64'h1234);
    // reset after five words of a D fill
    drain(); clr(); lat = 3; d_addr = 16'h4444; d_miss = 1;
    for (int n = 0; n < 40 && n_we_d < 5; n++) tick();
    rst = 1; d_miss = 0;
    tick();
    rst = 0;
    #2 chk("outputs after reset", 64'(outs()), 64'h0);
    repeat (6) tick();
    chk("dfill writes after reset", 64'(n_we_d), 64'd5);
    chk("dfill done after reset", 64'(n_done_d), 64'd0);
    // wrap at the top of memory, then a stray valid in IDLE
    drain(); clr(); lat = 2; d_addr = 16'hFFFA; d_miss = 1;
    for (int n = 0; n < 40 && n_done_d == 0; n++) tick();
    drain();
    chk("wrap first addr", 64'(first_addr), 64'hFFF0);
    chk("wrap last addr", 64'(last_addr), 64'hFFFE);
    stray_arm = 1;
    repeat (3) tick();
    chk("stray ignored", 64'(n_we_i + n_we_d), 64'd8);
    // back-to-back I fills with the request held
    drain(); clr(); auto_rel = 0; i_addr = 16'h0500; i_miss = 1;
    for (int n = 0; n < 40 && n_done_i == 0; n++) tick();
    i_addr = 16'h0200;
    for (int n = 0; n < 40 && n_done_i < 2; n++) tick();
    i_miss = 0; auto_rel = 1;
    tick();
    chk("b2b gap", 64'(gap), 64'd2);
    chk("b2b last addr", 64'(last_addr), 64'h020E);
    chk("b2b writes", 64'(n_we_i), 64'd16);
    // randomized traffic
    drain();
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!d_wr && $urandom_range(0, 11) == 0) begin
        d_wr_addr = rnd_addr() & 16'hFFFE; d_wr_data = 16'($urandom); d_wr = 1;
      end
      if (!d_miss && $urandom_range(0, 15) == 0) begin d_addr = rnd_addr(); d_miss = 1; end
      if (!i_miss && $urandom_range(0, 15) == 0) begin i_addr = rnd_addr(); i_miss = 1; end
      if (i_miss && $urandom_range(0, 149) == 0) i_miss = 0;
      if (d_miss && $urandom_range(0, 149) == 0) d_miss = 0;
      if (mk == 0 && q.size() == 0 && $urandom_range(0, 7) == 0) lat = $urandom_range(1, 5);
      if ($urandom_range(0, 29) == 0) stray_arm = 1;
    end
    {i_miss, d_miss, d_wr} = '0;
    drain();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction-cache and data-cache miss handlers, and directly upstream of the single-ported main memory (memory4c).
- Arbitrates three request sources onto the one memory port: I-cache line fills, D-cache line fills, and D-side write-through stores.
- Sequences each 8-word line fill: it issues pipelined reads and steers the returned words back to the requesting cache, with a word index and a completion pulse.

Parameters:
- LINE_WORDS, 8, 16-bit words per cache line (16-byte line).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_miss  in  1  I-cache miss request, level, held until i_fill_done.
- i_addr  in  16  I-cache miss address; bits [3:0] ignored.
- d_miss  in  1  D-cache miss request, level, held until d_fill_done.
- d_addr  in  16  D-cache miss address; bits [3:0] ignored.
- d_wr  in  1  store request, level, held until d_wr_ack.
- d_wr_addr  in  16  store word address.
- d_wr_data  in  16  store data.
- mem_rdata  in  16  memory read data.
- mem_rvalid  in  1  memory read data valid, one pulse per issued read.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_wr  out  1  memory write strobe.
- mem_en  out  1  memory enable (read or write issued this cycle).
- fill_data  out  16  returned word, shared by both caches.
- i_busy  out  1  I fill in progress.
- i_fill_we  out  1  write fill_data into the I-cache data array.
- i_fill_word  out  3  word index for i_fill_we.
- i_fill_done  out  1  one-cycle pulse: write the I tag, release i_miss.
- d_busy  out  1  D fill or store in progress.
- d_fill_we  out  1  write fill_data into the D-cache data array.
- d_fill_word  out  3  word index for d_fill_we.
- d_fill_done  out  1  one-cycle pulse: write the D tag.
- d_wr_ack  out  1  one-cycle pulse: store committed.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State goes to IDLE and both counters go to 0.
  - All outputs are 0: mem_addr, mem_wdata, fill_data, *_word, every strobe, busy and done.
- States: IDLE, WRITE, FILL_I, FILL_D.
- IDLE: requests are sampled every cycle with priority d_wr > d_miss > i_miss.
  - A grant latches base = {addr[15:4],4'h0} and moves to the target state on the next edge.
  - No memory access is issued in IDLE.
- WRITE: lasts exactly one cycle.
  - mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data.
  - d_wr_ack=1 in the same cycle; next state is IDLE.
- FILL_x issue side:
  - issue_cnt runs 0..LINE_WORDS. While issue_cnt<8: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt, then issue_cnt increments.
  - Exactly one read is issued per cycle; 8 reads go out in 8 consecutive cycles.
- FILL_x return side:
  - Each mem_rvalid pulse drives fill_data=mem_rdata combinationally, x_fill_we=1 and x_fill_word=recv_cnt[2:0]; then recv_cnt increments.
  - Returned words are counted by mem_rvalid pulses, not by a fixed latency, so the block works with any memory latency of 1 cycle or more.
- Fill completion:
  - On the cycle recv_cnt reaches 8: x_fill_done pulses for one cycle, x_busy drops, state returns to IDLE, and both counters clear.
  - A new grant can be taken in the following cycle.
- x_busy is 1 in every cycle of FILL_x. d_busy is also 1 in WRITE.
- No preemption: a fill or store always runs to completion. Requests arriving meanwhile wait in IDLE arbitration.
- Request deasserted mid-fill: ignored; the fill completes and done still pulses.
- mem_rvalid in IDLE or WRITE: ignored; no strobe is produced.
- Address arithmetic wraps modulo 2^16 (base 0xFFF0 gives last word 0xFFFE).
- Reset mid-fill: the operation is abandoned with no done pulse. Late mem_rvalid pulses after reset are ignored because the state is IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, WRITE, FILL_I, FILL_D};
  - LINE_WORDS=8;
  - WORD_BYTES=2;
  - CNT_W=$clog2(LINE_WORDS)+1.
- One natural sub-module, line_fill_seq. It holds issue_cnt, recv_cnt, base-address generation and the done detection, and is shared by both fill states. The top level holds the arbiter FSM and output steering.

Test Plan:
- I-fill alone (memory latency 4): i_miss=1, i_addr=0x1236 -> mem_addr 0x1230..0x123E on 8 consecutive cycles; i_fill_we on the 8 cycles from issue+4 with i_fill_word 0..7 and fill_data matching memory; i_fill_done pulses once; i_busy is high for 12 cycles.
- Simultaneous requests: d_wr(0x0040←0xBEEF), d_miss(0x2000) and i_miss(0x0100) in the same cycle -> order WRITE, FILL_D, FILL_I; d_wr_ack is a single pulse; memory at 0x0040 reads 0xBEEF; no memory access overlaps between grants.
- Store during fill: d_wr asserted on the 3rd cycle of FILL_I -> no mem_wr until i_fill_done; WRITE is granted the cycle after IDLE is re-entered.
- Reset mid-fill: rst asserted after 5 words of a D fill -> next cycle all outputs are 0 and state is IDLE; the remaining 3 mem_rvalid pulses produce no d_fill_we and no d_fill_done.
- Wrap and stray valid: d_addr=0xFFFA -> addresses 0xFFF0..0xFFFE. A mem_rvalid pulse injected in IDLE produces no fill strobes.
- Back-to-back fills: i_miss held high immediately after i_fill_done for a new line 0x0200 -> the second fill is granted the cycle after done, with correct word indices 0..7.
